// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced three-button editor for BCD time preset and alarm digits.
// Optional AUTO_REPEAT_EN adds a held-inc auto-repeat.
module time_set_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int DEB_W         = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_ok_i,
  input  logic [3:0] hourdec_now_i,
  input  logic [3:0] hourone_now_i,
  input  logic [3:0] mindec_now_i,
  input  logic [3:0] minone_now_i,
  output logic [3:0] hourdec_init_o,
  output logic [3:0] hourone_init_o,
  output logic [3:0] mindec_init_o,
  output logic [3:0] minone_init_o,
  output logic       time_load_o,
  output logic [3:0] hourdec_bud_o,
  output logic [3:0] hourone_bud_o,
  output logic [3:0] mindec_bud_o,
  output logic [3:0] minone_bud_o,
  output logic [2:0] edit_state_o,
  output logic       bud_sel_o,
  output logic [3:0] blink_mask_o
);
  typedef enum logic [2:0] {RUN = 3'd0, T_HR = 3'd1, T_MIN = 3'd2, B_HR = 3'd3, B_MIN = 3'd4} state_e;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  logic [2:0] raw, sync1_q, sync2_q, last_q, deb_q, deb_prev_q, press;
  logic [DEB_W-1:0] cnt_q [3];
  state_e state_q, state_d;
  logic [7:0] eh_q, eh_d, em_q, em_d, bh_q, bh_d, bm_q, bm_d, ih_q, im_q, seed_h, seed_m;
  logic load_d, load_q, bud_sel_d, bud_sel_q, seed_ok, pm, po, pi, rep;
  logic [3:0] blink_d, blink_q;
  assign raw = {btn_ok_i, btn_inc_i, btn_mode_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      last_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      last_q     <= sync2_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != last_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] != DEB_LAST) cnt_q[i] <= cnt_q[i] + 1'b1;
        if (sync2_q[i] == last_q[i] && cnt_q[i] == DEB_LAST) deb_q[i] <= sync2_q[i];
      end
    end
  end
  assign press = deb_q & ~deb_prev_q;
  // mode beats ok beats inc when pulses coincide
  assign pm = press[0];
  assign po = press[2] & ~pm;
  assign pi = (press[1] | rep) & ~pm & ~press[2];
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(2 * REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_q, rep_d;
  assign rep   = rep_q == RW'(2 * REPEAT_CYCLES);
  assign rep_d = (!deb_q[1] || state_d != state_q || state_q == RUN) ? '0 :
                 press[1] ? RW'(1) :
                 rep ? RW'(REPEAT_CYCLES + 1) :
                 (rep_q != '0) ? rep_q + 1'b1 : '0;
  always_ff @(posedge clk) rep_q <= rst ? '0 : rep_d;
`else
  assign rep = 1'b0;
`endif
  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    return (h == 8'h23) ? 8'h00 : (h[3:0] == 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    return (m[3:0] != 4'd9) ? {m[7:4], m[3:0] + 4'd1} : (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
  endfunction
  assign seed_ok = hourdec_now_i <= 4'd2 && hourone_now_i <= 4'd9 && mindec_now_i <= 4'd5 &&
                   minone_now_i <= 4'd9 && !(hourdec_now_i == 4'd2 && hourone_now_i > 4'd3);
  assign seed_h  = seed_ok ? {hourdec_now_i, hourone_now_i} : 8'h00;
  assign seed_m  = seed_ok ? {mindec_now_i, minone_now_i} : 8'h00;
  always_comb begin
    state_d = state_q;
    eh_d    = eh_q;
    em_d    = em_q;
    bh_d    = bh_q;
    bm_d    = bm_q;
    load_d  = 1'b0;
    case (state_q)
      RUN: if (pm) begin
        state_d = T_HR;
        eh_d    = seed_h;
        em_d    = seed_m;
      end
      T_HR: if (pm) state_d = T_MIN;
        else if (po) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (pi) eh_d = hr_inc(eh_q);
      T_MIN: if (pm || po) begin
          state_d = pm ? B_HR : RUN;
          load_d  = 1'b1;
        end else if (pi) em_d = min_inc(em_q);
      B_HR: if (pm || po) state_d = pm ? B_MIN : RUN;
        else if (pi) bh_d = hr_inc(bh_q);
      B_MIN: if (pm || po) state_d = RUN;
        else if (pi) bm_d = min_inc(bm_q);
      default: state_d = RUN;
    endcase
    blink_d   = (state_d == T_HR || state_d == B_HR) ? 4'b1100 :
                (state_d == T_MIN || state_d == B_MIN) ? 4'b0011 : 4'b0000;
    bud_sel_d = state_d == B_HR || state_d == B_MIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      eh_q      <= '0;
      em_q      <= '0;
      bh_q      <= '0;
      bm_q      <= '0;
      ih_q      <= '0;
      im_q      <= '0;
      load_q    <= 1'b0;
      blink_q   <= '0;
      bud_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      eh_q      <= eh_d;
      em_q      <= em_d;
      bh_q      <= bh_d;
      bm_q      <= bm_d;
      ih_q      <= load_d ? eh_q : ih_q;
      im_q      <= load_d ? em_q : im_q;
      load_q    <= load_d;
      blink_q   <= blink_d;
      bud_sel_q <= bud_sel_d;
    end
  end
  assign {hourdec_init_o, hourone_init_o} = ih_q;
  assign {mindec_init_o, minone_init_o}   = im_q;
  assign {hourdec_bud_o, hourone_bud_o}   = bh_q;
  assign {mindec_bud_o, minone_bud_o}     = bm_q;
  assign time_load_o  = load_q;
  assign edit_state_o = state_q;
  assign bud_sel_o    = bud_sel_q;
  assign blink_mask_o = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench with a time-of-day reference model for time_set_ctrl.
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0;
  logic [3:0] hd_now = '0, ho_now = '0, md_now = '0, mo_now = '0;
  logic [3:0] hd_init, ho_init, md_init, mo_init, hd_bud, ho_bud, md_bud, mo_bud, blink;
  logic time_load, bud_sel;
  logic [2:0] edit_state;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int n_vec = 0, n_err = 0;
  int st = 0, h = 0, m = 0, bh = 0, bm = 0, ih = 0, im = 0;
  int nd [4];

  always #5 clk = ~clk;

  time_set_ctrl #(.DEB_CYCLES(4), .DEB_W(20), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .btn_mode_i(btn_mode), .btn_inc_i(btn_inc), .btn_ok_i(btn_ok),
    .hourdec_now_i(hd_now), .hourone_now_i(ho_now), .mindec_now_i(md_now), .minone_now_i(mo_now),
    .hourdec_init_o(hd_init), .hourone_init_o(ho_init), .mindec_init_o(md_init), .minone_init_o(mo_init),
    .time_load_o(time_load),
    .hourdec_bud_o(hd_bud), .hourone_bud_o(ho_bud), .mindec_bud_o(md_bud), .minone_bud_o(mo_bud),
    .edit_state_o(edit_state), .bud_sel_o(bud_sel), .blink_mask_o(blink)
  );

  function automatic logic [15:0] digits(int hh, int mm);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every load strobe must match the oldest expected preset
  always @(negedge clk) begin
    if (!rst && time_load) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_load: got %0h expected none", {hd_init, ho_init, md_init, mo_init});
      end else begin
        mon_e = exp_q.pop_front();
        cmp("load_init", {hd_init, ho_init, md_init, mo_init}, mon_e);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic set_now(int a, int b, int c, int d);
    hd_now = 4'(a); ho_now = 4'(b); md_now = 4'(c); mo_now = 4'(d);
    nd[0] = a; nd[1] = b; nd[2] = c; nd[3] = d;
  endtask

  task automatic model_load();
    ih = h; im = m;
    exp_q.push_back(digits(h, m));
  endtask

  task automatic model_inc();
    case (st)
      1: h = (h + 1) % 24;
      2: m = (m + 1) % 60;
      3: bh = (bh + 1) % 24;
      4: bm = (bm + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic model_press(bit pm, bit po, bit pi);
    if (pm) begin
      case (st)
        0: begin
          if (nd[0] <= 9 && nd[1] <= 9 && nd[2] <= 9 && nd[3] <= 9 &&
              nd[0] * 10 + nd[1] <= 23 && nd[2] * 10 + nd[3] <= 59) begin
            h = nd[0] * 10 + nd[1]; m = nd[2] * 10 + nd[3];
          end else begin
            h = 0; m = 0;
          end
          st = 1;
        end
        1: st = 2;
        2: begin model_load(); st = 3; end
        3: st = 4;
        default: st = 0;
      endcase
    end else if (po) begin
      if (st == 1 || st == 2) model_load();
      st = 0;
    end else if (pi) model_inc();
  endtask

  task automatic check(string tag);
    cmp({tag, "_state"}, edit_state, st);
    cmp({tag, "_bud_sel"}, bud_sel, (st == 3 || st == 4));
    cmp({tag, "_blink"}, blink, (st == 1 || st == 3) ? 4'b1100 : (st == 2 || st == 4) ? 4'b0011 : 4'b0000);
    cmp({tag, "_bud"}, {hd_bud, ho_bud, md_bud, mo_bud}, digits(bh, bm));
    cmp({tag, "_init"}, {hd_init, ho_init, md_init, mo_init}, digits(ih, im));
  endtask

  task automatic press(bit pm, bit po, bit pi, int hold);
    model_press(pm, po, pi);
    @(negedge clk);
    btn_mode = pm; btn_ok = po; btn_inc = pi;
    repeat (hold) @(negedge clk);
    btn_mode = 0; btn_ok = 0; btn_inc = 0;
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    st = 0; h = 0; m = 0; bh = 0; bm = 0; ih = 0; im = 0;
    @(negedge clk);
    check("reset");
  endtask

  initial begin
    set_now(0, 0, 0, 0);
    do_reset();
    repeat (4) begin
      @(negedge clk); btn_mode = 1;
      repeat (3) @(negedge clk);
      btn_mode = 0;
      repeat (3) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    check("glitch");

    set_now(1, 2, 3, 4);
    press(1, 0, 0, 12); check("t_hr");
    repeat (2) press(0, 0, 1, 12);
    press(1, 0, 0, 12); check("t_min");
    repeat (3) press(0, 0, 1, 12);
    press(0, 1, 0, 12); check("ok_load");

    set_now(2, 3, 5, 9);
    press(1, 0, 0, 12);
    press(0, 0, 1, 12);
    press(1, 0, 0, 12);
    press(0, 0, 1, 12);
    press(1, 0, 0, 12); check("wrap_bhr");

    repeat (8) press(0, 0, 1, 12);
    check("bud_hr");
    press(1, 0, 0, 12);
    repeat (61) press(0, 0, 1, 12);
    check("bud_min");
    press(1, 0, 0, 12); check("bud_exit");

    set_now(0, 9, 1, 5);
    press(1, 0, 0, 12);
    press(1, 0, 1, 12); check("mode_inc");
    press(0, 1, 0, 12); check("prio_load");
    set_now(2, 10, 7, 7);
    press(1, 0, 0, 12);
    press(0, 1, 0, 12); check("bad_seed");

    press(1, 0, 0, 12);
    press(1, 0, 0, 12);
    repeat (2) press(0, 0, 1, 12);
    press(0, 0, 1, 44);
`ifdef AUTO_REPEAT_EN
    repeat (4) model_inc();
`endif
    check("held_inc");
    do_reset();

    for (int k = 0; k < 150; k++) begin
      int r;
      bit a, b, c;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) < 3) set_now($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      else set_now($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
      a = r < 20; b = r >= 20 && r < 32; c = r >= 32 && r < 85;
      if (r >= 85) begin
        a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
        if (!(a || b || c)) c = 1;
      end
      press(a, b, c, 12);
      check("rand");
    end
    repeat (5) @(negedge clk);
    cmp("pending_loads", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven setting controller that sits directly upstream of the alarm top.
- Produces the current-time preset digits (hourdec_init..minone_init) with a load strobe, and the alarm (bud) digits (hourdec_bud..minone_bud).
- Debounces three raw buttons and runs a mode FSM that edits BCD hours and minutes with correct wrap.
- Also outputs display hints: bud_sel and blink_mask.

Parameters:
- DEB_CYCLES, 4: clk cycles a synchronized button level must be stable before it is accepted. Use 4 in sim; large values on the board.
- DEB_W, 20: width of the debounce counter. Must satisfy DEB_CYCLES < 2**DEB_W.
- REPEAT_CYCLES, 8: auto-repeat period. Only used with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous reset, active-high
- btn_mode  in  1  raw mode button, asynchronous, active-high
- btn_inc  in  1  raw increment button, asynchronous, active-high
- btn_ok  in  1  raw confirm/exit button, asynchronous, active-high
- hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  current BCD time from the watch
- hourdec_init, hourone_init, mindec_init, minone_init  out  4 each  time preset digits, registered
- time_load  out  1  one-cycle strobe; the *_init outputs are valid on that cycle
- hourdec_bud, hourone_bud, mindec_bud, minone_bud  out  4 each  alarm digits, registered
- edit_state  out  3  0=RUN, 1=T_HR, 2=T_MIN, 3=B_HR, 4=B_MIN
- bud_sel  out  1  1 in B_HR/B_MIN: display shows the bud digits
- blink_mask  out  4  per-digit blink, MSB = hourdec

Behaviour:
- Reset (rst high at a clk edge):
  - edit_state=RUN.
  - All *_init and *_bud outputs = 0.
  - time_load=0, bud_sel=0, blink_mask=0.
  - Debounce state cleared, debounced levels = 0.
  - Reset mid-edit discards the edit and produces no time_load.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter reloads on every change of the synchronized level.
  - The debounced level takes the new value after DEB_CYCLES consecutive stable cycles.
  - A rising edge of the debounced level gives a one-cycle press pulse.
  - Press latency from a clean raw edge = DEB_CYCLES+3 cycles, ±1.
- Internal edit registers eh (0..23) and em (0..59) are held as BCD digit pairs.
- Seeding: entering T_HR from RUN copies the *_now inputs into eh/em. If any now digit > 9, or the hour > 23, or the minute > 59, the seed is 00:00.
- Transitions on a mode press:
  - RUN→T_HR
  - T_HR→T_MIN
  - T_MIN→B_HR, with a time_load pulse on the transition cycle
  - B_HR→B_MIN
  - B_MIN→RUN
- ok press:
  - From T_HR or T_MIN → RUN, with a time_load pulse.
  - From B_HR or B_MIN → RUN.
  - In RUN it is ignored.
- On a time_load pulse, *_init = eh/em, registered in the same cycle the pulse is high. *_init hold their value between loads.
- inc press:
  - T_HR: eh+1, wrap 23→00. hourone wraps 9→0 with hourdec+1.
  - T_MIN: em+1, wrap 59→00, no carry into the hour.
  - B_HR, B_MIN: same rules, applied directly to the *_bud outputs.
  - RUN: ignored.
- Simultaneous press pulses in one cycle: priority is mode > ok > inc; lower-priority pulses are dropped.
- blink_mask: T_HR/B_HR = 1100, T_MIN/B_MIN = 0011, RUN = 0000.
- bud_sel = 1 only in B_HR and B_MIN.
- Timing: all outputs are registered; edit_state, blink_mask and bud_sel change in the cycle after the press pulse.
- Encodings 5–7 of edit_state are unreachable; if entered, the FSM returns to RUN with no load.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While debounced inc stays high in an edit state, an extra inc pulse is generated every REPEAT_CYCLES cycles.
  - The first repeat comes 2*REPEAT_CYCLES cycles after the initial press.
  - The repeat counter clears on release, on a state change, and on rst.
- Undefined: exactly one inc per press; no repeat counter is synthesized.

Test Plan:
- rst for 2 cycles → all digit outputs 0, edit_state=0, time_load=0. Glitchy btn_mode (3-cycle pulses, DEB_CYCLES=4) → no state change.
- now=12:34; mode; inc ×2; mode; inc ×3; ok → edit_state path 0→1→2→0, single time_load with init=14:37.
- now=23:59; mode; inc; mode; inc; mode → init=00:00 loaded on T_MIN→B_HR, no hour carry; bud_sel=1, blink_mask=1100.
- In B_HR: inc ×8 → bud hour 08. Mode, then inc ×61 → bud minute 01. Mode → RUN, no time_load.
- mode and inc pulses forced in the same cycle while in T_HR → state T_MIN, eh unchanged. now=2A:77 then mode → seed 00:00.
- rst asserted in T_MIN after edits → RUN, init unchanged, no time_load. With AUTO_REPEAT_EN and REPEAT_CYCLES=8, hold inc 40 cycles past the press in T_MIN → em advanced by 1+4.
